// File: rtl/zx_spi_master.sv
// SPI mode-0 byte initiator for the zx128 SD interface: CPU writes send d, reads send 0xFF.
// Chip select is a separate CPU-loaded register that is independent of the shift engine.
module zx_spi_master #(
  parameter int DIV = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx,
  input  logic       rx,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       busy,
  input  logic       csWr,
  input  logic       csD,
  output logic       usdCk,
  output logic       usdCs,
  output logic       usdMosi,
  input  logic       usdMiso
);

  // state | meaning
  // IDLE  | no transfer; usdCk low, usdMosi high, waiting for tx/rx
  // SHIFT | 16 SCK half-periods; even ends sample MISO, odd ends shift
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_RELOAD = CW'(DIV - 1);

  state_t        state;
  logic [CW-1:0] divcnt;
  logic [3:0]    phase;
  logic [7:0]    sr;
  logic          rbit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      divcnt  <= DIV_RELOAD;
      phase   <= 4'd0;
      sr      <= 8'hFF;
      rbit    <= 1'b1;
      q       <= 8'hFF;
      busy    <= 1'b0;
      usdCk   <= 1'b0;
      usdCs   <= 1'b1;
      usdMosi <= 1'b1;
    end else begin
      if (csWr) usdCs <= csD;
      case (state)
        IDLE: begin
          if (tx || rx) begin
            sr      <= tx ? d : 8'hFF;
            usdMosi <= tx ? d[7] : 1'b1;
            phase   <= 4'd0;
            divcnt  <= DIV_RELOAD;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (divcnt == '0) begin
            divcnt <= DIV_RELOAD;
            phase  <= phase + 4'd1;
            if (phase == 4'd15) begin
              q       <= {sr[6:0], rbit};
              busy    <= 1'b0;
              usdCk   <= 1'b0;
              usdMosi <= 1'b1;
              state   <= IDLE;
            end else begin
              usdCk <= ~usdCk;
              if (!phase[0]) begin
                rbit <= usdMiso;
              end else begin
                // mosi mirrors the new sr[7] so it stays a plain register
                sr      <= {sr[6:0], rbit};
                usdMosi <= sr[6];
              end
            end
          end else begin
            divcnt <= divcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zx_spi_master.sv
// Directed bench for zx_spi_master: DIV=2 instance (loopback or responder) plus a DIV=1 instance.
module tb_zx_spi_master;

  logic       clk = 1'b0;
  logic       reset, tx, rx, csWr, csD, loop, sel;
  logic [7:0] d, resp0, resp1;
  logic [7:0] q0, q1;
  logic       busy0, busy1, ck0, ck1, cs0, cs1, mosi0, mosi1;
  logic [2:0] idx0, idx1;
  logic       miso0, miso1;
  int         vec = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  assign miso0 = loop ? mosi0 : resp0[3'd7 - idx0];
  assign miso1 = resp1[3'd7 - idx1];

  // responder shifts its next bit out after each falling SCK edge
  always @(negedge ck0 or posedge reset)
    if (reset) idx0 <= 3'd0; else idx0 <= idx0 + 3'd1;
  always @(negedge ck1 or posedge reset)
    if (reset) idx1 <= 3'd0; else idx1 <= idx1 + 3'd1;

  zx_spi_master #(.DIV(2)) u_div2 (
    .clock(clk), .reset(reset), .tx(tx), .rx(rx), .d(d), .q(q0), .busy(busy0),
    .csWr(csWr), .csD(csD), .usdCk(ck0), .usdCs(cs0), .usdMosi(mosi0), .usdMiso(miso0)
  );

  zx_spi_master #(.DIV(1)) u_div1 (
    .clock(clk), .reset(reset), .tx(tx), .rx(rx), .d(d), .q(q1), .busy(busy1),
    .csWr(csWr), .csD(csD), .usdCk(ck1), .usdCs(cs1), .usdMosi(mosi1), .usdMiso(miso1)
  );

  logic       s_busy, s_ck, s_mosi, s_cs;
  logic [7:0] s_q;
  assign s_busy = sel ? busy1 : busy0;
  assign s_ck   = sel ? ck1   : ck0;
  assign s_mosi = sel ? mosi1 : mosi0;
  assign s_cs   = sel ? cs1   : cs0;
  assign s_q    = sel ? q1    : q0;

  int         bcnt, pulses, toggles;
  logic [7:0] bits;
  logic       all1, prev_ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start(input logic t, input logic r, input logic [7:0] dv);
    tx = t; rx = r; d = dv;
    step();
    tx = 1'b0; rx = 1'b0;
  endtask

  // Follows one transfer from the cycle after the start strobe until busy falls.
  task automatic run(input int tx_at, input int cs_at);
    bcnt = 0; pulses = 0; toggles = 0; bits = 8'h00; all1 = 1'b1; prev_ck = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!s_busy) break;
      bcnt++;
      if (prev_ck != s_ck) toggles++;
      if (!prev_ck && s_ck) begin
        pulses++;
        bits = {bits[6:0], s_mosi};
      end
      all1 = all1 & s_mosi;
      prev_ck = s_ck;
      if (cs_at > 0 && bcnt == cs_at + 1) chk("cs_drop", s_cs, 1'b0);
      tx = (bcnt == tx_at);
      if (tx) d = 8'hFF;
      csWr = (bcnt == cs_at);
      if (csWr) csD = 1'b0;
      step();
    end
    tx = 1'b0; csWr = 1'b0;
    if (prev_ck != s_ck) toggles++;
    chk("timeout", s_busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; tx = 1'b0; rx = 1'b0; d = 8'h00; csWr = 1'b0; csD = 1'b1;
    loop = 1'b1; sel = 1'b0; resp0 = 8'hFF; resp1 = 8'hFF;
    step(); step();
    reset = 1'b0;
    chk("rst_ck", ck0, 1'b0);
    chk("rst_cs", cs0, 1'b1);
    chk("rst_mosi", mosi0, 1'b1);
    chk("rst_q", q0, 8'hFF);
    chk("rst_busy", busy0, 1'b0);

    // loopback A5
    start(1'b1, 1'b0, 8'hA5);
    run(0, 0);
    chk("lb_bits", bits, 8'hA5);
    chk("lb_pulses", pulses, 8);
    chk("lb_busy", bcnt, 32);
    chk("lb_q", q0, 8'hA5);
    chk("lb_ck", ck0, 1'b0);
    chk("lb_mosi", mosi0, 1'b1);

    // rx with responder 3C
    loop = 1'b0; resp0 = 8'h3C;
    start(1'b0, 1'b1, 8'h00);
    run(0, 0);
    chk("rx_mosi_all1", all1, 1'b1);
    chk("rx_q", q0, 8'h3C);
    chk("rx_busy", bcnt, 32);

    // tx and rx together: tx wins
    loop = 1'b1;
    start(1'b1, 1'b1, 8'h12);
    run(0, 0);
    chk("pri_bits", bits, 8'h12);
    chk("pri_q", q0, 8'h12);

    // tx while busy is ignored
    start(1'b1, 1'b0, 8'h5A);
    run(10, 0);
    chk("ign_bits", bits, 8'h5A);
    chk("ign_q", q0, 8'h5A);
    chk("ign_busy", bcnt, 32);

    // chip select written mid-transfer
    loop = 1'b0; resp0 = 8'hC3;
    start(1'b0, 1'b1, 8'h00);
    run(0, 12);
    chk("cs_q", q0, 8'hC3);
    chk("cs_busy", bcnt, 32);
    csWr = 1'b1; csD = 1'b1;
    step();
    csWr = 1'b0;
    chk("cs_rise", cs0, 1'b1);

    // reset at the 5th rising SCK edge, with cs low beforehand
    csWr = 1'b1; csD = 1'b0;
    step();
    csWr = 1'b0;
    chk("cs_low", cs0, 1'b0);
    loop = 1'b1;
    start(1'b1, 1'b0, 8'hA5);
    pulses = 0; prev_ck = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!prev_ck && ck0) pulses++;
      prev_ck = ck0;
      if (pulses == 5) break;
      step();
    end
    chk("ab_pulses", pulses, 5);
    reset = 1'b1;
    step();
    chk("ab_ck", ck0, 1'b0);
    chk("ab_cs", cs0, 1'b1);
    chk("ab_mosi", mosi0, 1'b1);
    chk("ab_busy", busy0, 1'b0);
    chk("ab_q", q0, 8'hFF);
    reset = 1'b0;
    step();
    start(1'b1, 1'b0, 8'h6E);
    run(0, 0);
    chk("post_q", q0, 8'h6E);
    chk("post_busy", bcnt, 32);

    // DIV=1 instance, rx with responder 81
    step(); step();
    sel = 1'b1; resp1 = 8'h81;
    start(1'b0, 1'b1, 8'h00);
    run(0, 0);
    chk("d1_busy", bcnt, 16);
    chk("d1_toggles", toggles, 16);
    chk("d1_pulses", pulses, 8);
    chk("d1_q", q1, 8'h81);
    chk("d1_ck", ck1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
